// File: rtl/write_stream_adapter_pkg.sv
// Shared definitions for the write-side stream adapter.
//   gray_max_w : widest pointer the gray decoder handles
//   gray2bin   : gray-to-binary decode of the low 'width' bits of 'gray'
package write_stream_adapter_pkg;

  localparam int gray_max_w = 32;

  // Binary bit i is the XOR of gray bits [width-1:i]; walk from the MSB
  // down, keeping a running parity.
  function automatic logic [gray_max_w-1:0] gray2bin(
    input logic [gray_max_w-1:0] gray,
    input int                    width
  );
    logic [gray_max_w-1:0] bin;
    logic                  acc;
    bin = '0;
    acc = 1'b0;
    for (int i = gray_max_w - 1; i >= 0; i--) begin
      if (i < width) begin
        acc    = acc ^ gray[i];
        bin[i] = acc;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/write_stream_adapter_gray.sv
// Combinational gray-to-binary converter for one FIFO pointer.
//   gray : gray-coded pointer (width bits)
//   bin  : binary equivalent  (width bits)
module gray_to_binary
  import write_stream_adapter_pkg::*;
#(
  parameter int width = 4
) (
  input  logic [width-1:0] gray,
  output logic [width-1:0] bin
);

  assign bin = width'(gray2bin(gray_max_w'(gray), width));

endmodule

// File: rtl/write_stream_adapter.sv
// Write-side front end of the async FIFO (write clock domain).
// A valid/ready input stream is buffered through an output register plus a
// skid register, and words are issued as write_en/write_data only while the
// FIFO is not full. A registered fill level and almost_full flag are derived
// from the write gray pointer and the synchronised read gray pointer.
//   write_clk, write_rst      : clock, synchronous active-high reset
//   in_valid, in_data, in_ready : upstream stream
//   fifo_full                 : full flag from write_ctrl
//   write_ptr_gray            : write pointer (gray)
//   read_ptr_gray_sync        : read pointer (gray), already in write_clk
//   write_en, write_data      : write request and word to memory
//   fifo_level, almost_full   : registered occupancy and threshold flag
module write_stream_adapter
  import write_stream_adapter_pkg::*;
#(
  parameter int addr_size          = 3,
  parameter int data_size          = 8,
  parameter int almost_full_thresh = 6
) (
  input  logic                 write_clk,
  input  logic                 write_rst,
  input  logic                 in_valid,
  input  logic [data_size-1:0] in_data,
  output logic                 in_ready,
  input  logic                 fifo_full,
  input  logic [addr_size:0]   write_ptr_gray,
  input  logic [addr_size:0]   read_ptr_gray_sync,
  output logic                 write_en,
  output logic [data_size-1:0] write_data,
  output logic [addr_size:0]   fifo_level,
  output logic                 almost_full
);

  localparam int               ptr_w  = addr_size + 1;
  localparam logic [ptr_w-1:0] thresh = ptr_w'(almost_full_thresh);

  logic                 out_valid;
  logic [data_size-1:0] out_data;
  logic                 skid_valid;
  logic [data_size-1:0] skid_data;
  logic                 accept;
  logic                 drain;
  logic [ptr_w-1:0]     wbin;
  logic [ptr_w-1:0]     rbin;
  logic [ptr_w-1:0]     level_next;

  // in_ready comes straight from a flop, so it is glitch-free.
  assign in_ready   = !skid_valid;
  assign write_en   = out_valid && !fifo_full;
  assign write_data = out_data;
  assign accept     = in_valid && in_ready;
  assign drain      = write_en;

  gray_to_binary #(.width(ptr_w)) u_wbin (
    .gray (write_ptr_gray),
    .bin  (wbin)
  );

  gray_to_binary #(.width(ptr_w)) u_rbin (
    .gray (read_ptr_gray_sync),
    .bin  (rbin)
  );

  // Modulo-2^ptr_w subtraction absorbs pointer wrap.
  assign level_next = wbin - rbin;

  // Output/skid stage. The output slot is free when empty or draining;
  // the skid word has priority over new input to keep order. While the
  // skid is full in_ready is low, so no accept can coincide with a refill
  // from the skid.
  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
    end else if (!out_valid || drain) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // Skid payload needs no reset; it is only observed behind skid_valid.
  always_ff @(posedge write_clk) begin
    if (accept && out_valid && !drain) begin
      skid_data <= in_data;
    end
  end

  // Level stage. almost_full is judged on the new level, not the old one.
  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      fifo_level  <= '0;
      almost_full <= 1'b0;
    end else begin
      fifo_level  <= level_next;
      almost_full <= (level_next >= thresh);
    end
  end

endmodule

// File: tb/tb_write_stream_adapter.sv
// Self-checking bench for write_stream_adapter: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_write_stream_adapter;

  localparam int AS = 3;
  localparam int DS = 8;
  localparam int TH = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [DS-1:0] in_data = '0;
  logic         fifo_full = 1'b0;
  logic [AS:0]  wg = '0;
  logic [AS:0]  rg = '0;
  logic         in_ready;
  logic         write_en;
  logic [DS-1:0] write_data;
  logic [AS:0]  fifo_level;
  logic         almost_full;

  int tests = 0;
  int fails = 0;

  write_stream_adapter #(
    .addr_size          (AS),
    .data_size          (DS),
    .almost_full_thresh (TH)
  ) dut (
    .write_clk          (clk),
    .write_rst          (rst),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .fifo_full          (fifo_full),
    .write_ptr_gray     (wg),
    .read_ptr_gray_sync (rg),
    .write_en           (write_en),
    .write_data         (write_data),
    .fifo_level         (fifo_level),
    .almost_full        (almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The adapter is a two-word in-order buffer: ready while it holds fewer
  // than two words, writes its oldest word whenever not full.
  logic [DS-1:0] q[$];
  int            m_level = 0;
  bit            m_af = 1'b0;
  bit            check_en = 1'b0;

  function automatic int g2b(input logic [AS:0] g);
    logic [AS:0] b;
    b = g;
    for (int s = 1; s <= AS; s++) b = b ^ (g >> s);
    return int'(b);
  endfunction

  function automatic logic [AS:0] b2g(input int b);
    logic [AS:0] v;
    v = (AS+1)'(b);
    return v ^ (v >> 1);
  endfunction

  always @(posedge clk) begin
    bit wen;
    bit acc;
    if (rst) begin
      q.delete();
      m_level = 0;
      m_af    = 1'b0;
    end else begin
      wen = (q.size() > 0) && !fifo_full;
      acc = in_valid && (q.size() < 2);
      if (wen) void'(q.pop_front());
      if (acc) q.push_back(in_data);
      m_level = (g2b(wg) - g2b(rg) + 16) % 16;
      m_af    = (m_level >= TH);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("m_write_en", 32'(write_en), 32'((q.size() > 0) && !fifo_full));
      if ((q.size() > 0) && !fifo_full)
        check("m_write_data", 32'(write_data), 32'(q[0]));
      check("m_fifo_level", 32'(fifo_level), 32'(m_level));
      check("m_almost_full", 32'(almost_full), 32'(m_af));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input bit rdy, input bit we, input logic [DS-1:0] d);
    @(negedge clk);
    check({tag, "_ready"}, 32'(in_ready), 32'(rdy));
    check({tag, "_we"}, 32'(write_en), 32'(we));
    if (we) check({tag, "_data"}, 32'(write_data), 32'(d));
  endtask

  task automatic chk_lvl(input string tag, input int lvl, input bit af);
    @(negedge clk);
    check({tag, "_level"}, 32'(fifo_level), 32'(lvl));
    check({tag, "_af"}, 32'(almost_full), 32'(af));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit held;
    int rb;
    int lv;

    // Reset for two cycles
    rst = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(write_en), 32'd0);
    check("rst_data", 32'(write_data), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_af", 32'(almost_full), 32'd0);
    rst = 1'b0;
    check_en = 1'b1;

    // Streaming
    cyc(); in_valid = 1'b1; in_data = 8'h11; chk_out("s0", 1, 0, 8'h00);
    cyc(); in_data = 8'h22;                  chk_out("s1", 1, 1, 8'h11);
    cyc(); in_data = 8'h33;                  chk_out("s2", 1, 1, 8'h22);
    cyc(); in_valid = 1'b0;                  chk_out("s3", 1, 1, 8'h33);
    cyc();                                   chk_out("s4", 1, 0, 8'h00);

    // Backpressure
    cyc(); fifo_full = 1'b1; in_valid = 1'b1; in_data = 8'hA1; chk_out("b0", 1, 0, 8'h00);
    cyc(); in_data = 8'hA2;                  chk_out("b1", 1, 0, 8'h00);
    cyc(); in_data = 8'hA3;                  chk_out("b2", 0, 0, 8'h00);
    cyc();                                   chk_out("b3", 0, 0, 8'h00);
    cyc(); fifo_full = 1'b0;                 chk_out("b4", 0, 1, 8'hA1);
    cyc();                                   chk_out("b5", 1, 1, 8'hA2);
    cyc(); in_valid = 1'b0;                  chk_out("b6", 1, 1, 8'hA3);
    cyc();                                   chk_out("b7", 1, 0, 8'h00);

    // Level, no wrap, then wrap
    cyc(); wg = 4'b1100; rg = 4'b0000;
    cyc(); rg = 4'b0110;                     chk_lvl("l8", 8, 1);
    cyc(); wg = 4'b0001; rg = 4'b1000;       chk_lvl("l4", 4, 0);
    cyc(); wg = 4'b0101; rg = 4'b0000;       chk_lvl("lw2", 2, 0);
    cyc();                                   chk_lvl("l6", 6, 1);

    // Mid-operation reset with both registers full
    cyc(); fifo_full = 1'b1; in_valid = 1'b1; in_data = 8'hB1;
    cyc(); in_data = 8'hB2;
    cyc(); in_valid = 1'b0;                  chk_out("mr_full", 0, 0, 8'h00);
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; fifo_full = 1'b0;     chk_out("mr_after", 1, 0, 8'h00);
    check("mr_data", 32'(write_data), 32'd0);
    check("mr_level0", 32'(fifo_level), 32'd0);
    check("mr_af0", 32'(almost_full), 32'd0);
    cyc();                                   chk_out("mr_nowrite", 1, 0, 8'h00);
    check("mr_level6", 32'(fifo_level), 32'd6);
    check("mr_af1", 32'(almost_full), 32'd1);

    // Randomized traffic; upstream holds a word it could not hand over
    for (int n = 0; n < 3000; n++) begin
      held = in_valid && !in_ready;
      cyc();
      rst = ($urandom_range(0, 199) == 0);
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = DS'($urandom);
      end
      fifo_full = ($urandom_range(0, 2) == 0);
      rb = int'($urandom_range(0, 15));
      lv = int'($urandom_range(0, 8));
      rg = b2g(rb);
      wg = b2g((rb + lv) % 16);
      @(negedge clk);
    end

    cyc();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
